// File: rtl/fan_run_controller.sv
// Fan motor run sequencer: power/speed/sleep-timer events drive a soft-start /
// soft-stop FSM that ramps the PWM duty toward the selected speed level.
module fan_run_controller #(
  parameter logic [7:0] DUTY_L1    = 8'd85,
  parameter logic [7:0] DUTY_L2    = 8'd170,
  parameter logic [7:0] DUTY_L3    = 8'd255,
  parameter logic [7:0] RAMP_STEP  = 8'd5,
  parameter logic [7:0] RAMP_TICKS = 8'd10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       tick,
  input  logic       btn_power,
  input  logic       btn_speed,
  input  logic       timer_expired,
  output logic [7:0] duty,
  output logic [1:0] speed_level,
  output logic       fan_on,
  output logic       timer_clear,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] level_q, level_d;
  logic       fan_on_q, fan_on_d;
  logic       tclr_q, tclr_d;
  logic       level_adv;
  logic [7:0] target;
  logic       ramp_active;
  logic       step_hit;
  logic [8:0] up_sum;
  logic [8:0] dn_diff;
  logic [7:0] duty_step;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q  <= S_IDLE;
      duty_q   <= 8'd0;
      cnt_q    <= 8'd0;
      level_q  <= 2'd1;
      fan_on_q <= 1'b0;
      tclr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      fan_on_q <= fan_on_d;
      tclr_q   <= tclr_d;
    end
  end

  // Next-state decode; priority is power > expired > speed
  always_comb begin
    state_d   = state_q;
    level_adv = 1'b0;
    tclr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_power) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (btn_power) begin
          state_d = S_STOP;
          tclr_d  = 1'b1;
        end else if (timer_expired) begin
          state_d = S_STOP;
        end else if (btn_speed) begin
          level_adv = 1'b1;
        end else if (duty_q == target) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (btn_power) begin
          state_d = S_STOP;
          tclr_d  = 1'b1;
        end else if (timer_expired) begin
          state_d = S_STOP;
        end else if (btn_speed) begin
          level_adv = 1'b1;
          state_d   = S_RAMP;
        end
      end
      S_STOP: begin
        if (btn_power) state_d = S_RAMP;
        else if (duty_q == 8'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ramp datapath: target select, tick counter and saturating duty step
  always_comb begin
    case (level_q)
      2'd2:    target = DUTY_L2;
      2'd3:    target = DUTY_L3;
      default: target = DUTY_L1;
    endcase
    if (state_q == S_STOP) target = 8'd0;

    level_d = level_q;
    if (level_adv) level_d = (level_q == 2'd3) ? 2'd1 : 2'(level_q + 2'd1);

    fan_on_d = (state_d != S_IDLE);

    // Counter only runs while staying in a ramping state with no level change
    ramp_active = ((state_q == S_RAMP) || (state_q == S_STOP)) &&
                  (state_d == state_q) && !level_adv;
    step_hit    = ramp_active && tick && (8'(cnt_q + 8'd1) == RAMP_TICKS);

    up_sum  = 9'(duty_q) + 9'(RAMP_STEP);
    dn_diff = 9'(duty_q) - 9'(RAMP_STEP);
    if (duty_q < target)
      duty_step = (up_sum > 9'(target)) ? target : up_sum[7:0];
    else
      duty_step = (dn_diff[8] || (dn_diff[7:0] < target)) ? target : dn_diff[7:0];

    duty_d = duty_q;
    cnt_d  = cnt_q;
    if (!ramp_active) begin
      cnt_d = 8'd0;
    end else if (step_hit) begin
      cnt_d  = 8'd0;
      duty_d = duty_step;
    end else if (tick) begin
      cnt_d = 8'(cnt_q + 8'd1);
    end
  end

  assign duty        = duty_q;
  assign speed_level = level_q;
  assign fan_on      = fan_on_q;
  assign timer_clear = tclr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fan_run_controller.sv
// Directed scoreboard bench for fan_run_controller: expected duty ramps are
// queued from a reference model and popped as each duty change appears.
module tb_fan_run_controller;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       tick;
  logic       btn_power, btn_speed, timer_expired;
  logic [7:0] duty;
  logic [1:0] speed_level;
  logic       fan_on, timer_clear;
  logic [1:0] state_dbg;

  logic       sat_power;
  logic [7:0] sat_duty;
  logic [1:0] sat_level, sat_state;
  logic       sat_fan_on, sat_tclr;

  int n_vec = 0;
  int n_err = 0;
  int tclr_cycles = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fan_run_controller #(.RAMP_STEP(8'd17), .RAMP_TICKS(8'd2)) dut (
    .clk(clk), .reset_p(reset_p), .tick(tick),
    .btn_power(btn_power), .btn_speed(btn_speed), .timer_expired(timer_expired),
    .duty(duty), .speed_level(speed_level), .fan_on(fan_on),
    .timer_clear(timer_clear), .state_dbg(state_dbg)
  );

  fan_run_controller #(.RAMP_STEP(8'd100), .RAMP_TICKS(8'd2)) u_sat (
    .clk(clk), .reset_p(reset_p), .tick(tick),
    .btn_power(sat_power), .btn_speed(1'b0), .timer_expired(1'b0),
    .duty(sat_duty), .speed_level(sat_level), .fan_on(sat_fan_on),
    .timer_clear(sat_tclr), .state_dbg(sat_state)
  );

  always @(posedge clk) if (timer_clear === 1'b1) tclr_cycles++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cur_duty(input bit sel);
    return sel ? sat_duty : duty;
  endfunction

  function automatic logic [1:0] cur_state(input bit sel);
    return sel ? sat_state : state_dbg;
  endfunction

  // Reference ramp: saturating steps from start toward target
  function automatic void push_ramp(input int start, input int target, input int step);
    int cur = start;
    while (cur != target) begin
      if (cur < target) cur = (cur + step > target) ? target : cur + step;
      else              cur = (cur - step < target) ? target : cur - step;
      exp_q.push_back(cur);
    end
  endfunction

  // One-cycle pulse; returns 1 ns after the edge that sampled it
  task automatic pulse(input logic p, input logic s, input logic e);
    btn_power = p; btn_speed = s; timer_expired = e;
    @(posedge clk); #1;
    btn_power = 1'b0; btn_speed = 1'b0; timer_expired = 1'b0;
  endtask

  task automatic collect(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      logic [7:0] prev;
      bit seen;
      int e;
      prev = cur_duty(sel);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk); #1;
        if (cur_duty(sel) !== prev) seen = 1'b1;
      end
      n_vec++;
      assert (seen) else begin
        n_err++;
        $error("FAIL duty_timeout: observed %0d expected change from %0d", cur_duty(sel), prev);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("duty_ramp", 32'(cur_duty(sel)), 32'(e));
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input bit sel, input string tag);
    for (int c = 0; c < limit && cur_state(sel) !== s; c++) begin
      @(posedge clk); #1;
    end
    chk(tag, 32'(cur_state(sel)), 32'(s));
  endtask

  initial begin
    reset_p = 1'b1; tick = 1'b1;
    btn_power = 1'b0; btn_speed = 1'b0; timer_expired = 1'b0; sat_power = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_level", 32'(speed_level), 32'd1);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_fan_on", 32'(fan_on), 32'd0);
    chk("rst_tclr", 32'(timer_clear), 32'd0);
    reset_p = 1'b0;
    @(posedge clk); #1;

    // Power on from IDLE at level 1
    pulse(1, 0, 0);
    chk("on_state", 32'(state_dbg), 32'd1);
    chk("on_fan_on", 32'(fan_on), 32'd1);
    push_ramp(0, 85, 17);
    collect(5, 0);
    wait_state(2'd2, 5, 0, "l1_run");
    chk("l1_tclr_count", 32'(tclr_cycles), 32'd0);

    // Cycle levels 2, 3, then back to 1 (ramp down)
    pulse(0, 1, 0);
    chk("l2_state", 32'(state_dbg), 32'd1);
    chk("l2_level", 32'(speed_level), 32'd2);
    push_ramp(85, 170, 17);
    collect(5, 0);
    wait_state(2'd2, 5, 0, "l2_run");
    pulse(0, 1, 0);
    chk("l3_level", 32'(speed_level), 32'd3);
    push_ramp(170, 255, 17);
    collect(5, 0);
    wait_state(2'd2, 5, 0, "l3_run");
    pulse(0, 1, 0);
    chk("wrap_level", 32'(speed_level), 32'd1);
    push_ramp(255, 85, 17);
    collect(10, 0);
    wait_state(2'd2, 5, 0, "l1b_run");
    pulse(0, 1, 0);
    push_ramp(85, 170, 17);
    collect(5, 0);
    wait_state(2'd2, 5, 0, "l2b_run");

    // Manual off from RUN, speed ignored in STOP, restart at 102
    pulse(1, 0, 0);
    chk("off_state", 32'(state_dbg), 32'd3);
    chk("off_tclr", 32'(timer_clear), 32'd1);
    @(posedge clk); #1;
    chk("off_tclr_width", 32'(timer_clear), 32'd0);
    push_ramp(170, 0, 17);
    collect(2, 0);
    pulse(0, 1, 0);
    chk("stop_spd_level", 32'(speed_level), 32'd2);
    chk("stop_spd_state", 32'(state_dbg), 32'd3);
    collect(2, 0);
    exp_q.delete();
    chk("restart_from", 32'(duty), 32'd102);
    pulse(1, 0, 0);
    chk("restart_state", 32'(state_dbg), 32'd1);
    chk("restart_tclr", 32'(timer_clear), 32'd0);
    push_ramp(102, 170, 17);
    collect(4, 0);
    wait_state(2'd2, 5, 0, "restart_run");

    pulse(1, 0, 0);
    chk("off2_tclr", 32'(timer_clear), 32'd1);
    push_ramp(170, 0, 17);
    collect(10, 0);
    wait_state(2'd0, 5, 0, "idle_state");
    chk("idle_fan_on", 32'(fan_on), 32'd0);
    chk("idle_level", 32'(speed_level), 32'd2);

    // IDLE ignores speed and expiry
    pulse(0, 1, 1);
    chk("idle_ign_state", 32'(state_dbg), 32'd0);
    chk("idle_ign_level", 32'(speed_level), 32'd2);

    // Sleep timer expiry: stop without clearing the timer
    pulse(1, 0, 0);
    wait_state(2'd2, 40, 0, "pre_exp_run");
    pulse(0, 0, 1);
    chk("exp_state", 32'(state_dbg), 32'd3);
    chk("exp_tclr", 32'(timer_clear), 32'd0);
    wait_state(2'd0, 60, 0, "exp_idle");

    // Simultaneous power+expired, then power+speed in STOP
    pulse(1, 0, 0);
    wait_state(2'd2, 40, 0, "pre_both_run");
    pulse(1, 0, 1);
    chk("both_state", 32'(state_dbg), 32'd3);
    chk("both_tclr", 32'(timer_clear), 32'd1);
    pulse(1, 1, 0);
    chk("pwrspd_state", 32'(state_dbg), 32'd1);
    chk("pwrspd_level", 32'(speed_level), 32'd2);
    wait_state(2'd2, 10, 0, "pwrspd_run");
    chk("tclr_total", 32'(tclr_cycles), 32'd3);

    // Saturating step: 0 -> 85 in a single step
    sat_power = 1'b1;
    @(posedge clk); #1;
    sat_power = 1'b0;
    chk("sat_state", 32'(sat_state), 32'd1);
    push_ramp(0, 85, 100);
    collect(1, 1);
    wait_state(2'd2, 5, 1, "sat_run");

    // Asynchronous reset in the middle of a ramp
    pulse(0, 1, 0);
    push_ramp(170, 255, 17);
    collect(1, 0);
    exp_q.delete();
    #3 reset_p = 1'b1;
    #1;
    chk("arst_duty", 32'(duty), 32'd0);
    chk("arst_level", 32'(speed_level), 32'd1);
    chk("arst_state", 32'(state_dbg), 32'd0);
    chk("arst_fan_on", 32'(fan_on), 32'd0);
    chk("arst_sat_duty", 32'(sat_duty), 32'd0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
